div_iter: RTL and testbench

//  Multi-cycle unsigned radix-2 restoring divider; the responder on the M-extension execute

---
 rtl/div_iter_pkg.sv | 17 +
 rtl/div_iter_step.sv | 23 ++
 rtl/div_iter.sv | 141 ++++++++++++++
 tb/tb_div_iter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the width of the step counter.
package div_iter_pkg;

  // Divider control states, held in a 2-bit register
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Counter must hold the value XLEN itself, hence the extra bit
  function automatic int div_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            quo_msb,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  // The incoming remainder is always < b, so the shifted value fits in
  // XLEN+1 bits and the restored remainder fits back into XLEN bits.
  always_comb begin
    shifted  = {rem, quo_msb};
    q_bit    = (shifted >= {1'b0, b});
    rem_next = q_bit ? (shifted[XLEN-1:0] - b) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle unsigned radix-2 restoring divider with a req/ready
// handshake. Returns quotient or remainder as chosen per request.
// Optional build macro DIV_ITER_FAST_EN: b=0, a<b and b=1 complete
// straight from IDLE without iterating.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            is_q_i,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CNT_W    = div_cnt_w(XLEN);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  div_state_e        state_reg,  state_next;
  logic [XLEN-1:0]   rem_reg,    rem_next;
  logic [XLEN-1:0]   quo_reg,    quo_next;
  logic [XLEN-1:0]   b_reg,      b_next;
  logic              is_q_reg,   is_q_next;
  logic [CNT_W-1:0]  count_reg,  count_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic              ready_reg,  ready_next;

  logic [XLEN-1:0]   step_rem;
  logic              step_q;
  logic [XLEN-1:0]   step_quo;

  // Dividend bits are shifted out of the quotient register MSB-first
  // while quotient bits fill in from the LSB.
  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_reg),
    .quo_msb  (quo_reg[XLEN-1]),
    .b        (b_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign step_quo = {quo_reg[XLEN-2:0], step_q};

  // State and datapath registers; reset clears everything at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= DIV_IDLE;
      rem_reg    <= '0;
      quo_reg    <= '0;
      b_reg      <= '0;
      is_q_reg   <= 1'b0;
      count_reg  <= '0;
      result_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      b_reg      <= b_next;
      is_q_reg   <= is_q_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  // Next-state and datapath update; ready is produced one cycle ahead
  // so the output comes straight from a flop.
  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    b_next      = b_reg;
    is_q_next   = is_q_reg;
    count_next  = count_reg;
    result_next = result_reg;
    ready_next  = 1'b0;

    case (state_reg)
      DIV_IDLE: begin
        if (req_i) begin
          quo_next   = a_i;
          b_next     = b_i;
          is_q_next  = is_q_i;
          rem_next   = '0;
          count_next = CNT_INIT;
          state_next = DIV_BUSY;
`ifdef DIV_ITER_FAST_EN
          if (b_i == '0) begin
            result_next = is_q_i ? '1 : a_i;
            ready_next  = 1'b1;
            state_next  = DIV_DONE;
          end else if (a_i < b_i) begin
            result_next = is_q_i ? '0 : a_i;
            ready_next  = 1'b1;
            state_next  = DIV_DONE;
          end else if (b_i == XLEN'(1)) begin
            result_next = is_q_i ? a_i : '0;
            ready_next  = 1'b1;
            state_next  = DIV_DONE;
          end
`endif
        end
      end

      DIV_BUSY: begin
        // A dropped request is a pipeline flush: abandon the division
        // and leave the previous result untouched.
        if (!req_i) begin
          state_next = DIV_IDLE;
        end else begin
          rem_next   = step_rem;
          quo_next   = step_quo;
          count_next = count_reg - CNT_LAST;
          if (count_reg == CNT_LAST) begin
            result_next = is_q_reg ? step_quo : step_rem;
            ready_next  = 1'b1;
            state_next  = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        state_next = DIV_IDLE;
      end

      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  assign ready_o  = ready_reg;
  assign result_o = result_reg;

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomised checks for div_iter at XLEN=32.
module tb_div_iter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        is_q  = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        ready;
  logic [31:0] result;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam int LAT_NORM = 33;
`ifdef DIV_ITER_FAST_EN
  localparam int LAT_FAST = 1;
`else
  localparam int LAT_FAST = 33;
`endif

  always #5 clk = ~clk;

  div_iter #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .a_i      (a),
    .b_i      (b),
    .is_q_i   (is_q),
    .ready_o  (ready),
    .result_o (result)
  );

  // ready must only appear after a cycle in which req was high
  logic req_d = 1'b0;
  always @(posedge clk) req_d <= req;
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      vec_cnt++;
      if (req_d !== 1'b1) begin
        err_cnt++;
        $display("FAIL ready_follows_req: ready=1 with previous req=%b, want 1", req_d);
      end
    end
  end

  // Issue one request from an IDLE cycle; return result and latency (-1 on timeout).
  // Without keep, req drops in the DONE cycle and the task returns in the next (IDLE) cycle.
  task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input logic qv,
                        input bit keep, output logic [31:0] res, output int lat);
    @(negedge clk);
    a = av; b = bv; is_q = qv; req = 1'b1;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
    end
    if (!keep) begin
      req = 1'b0;
      @(posedge clk); #1;
    end
    $display("div a=%h b=%h is_q=%0d -> result=%h latency=%0d", av, bv, qv, res, lat);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int          l;
    #12;
    vec_cnt++;
    if (ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b want 0", ready); end
    vec_cnt++;
    if (result !== 32'd0) begin err_cnt++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
    do_div(32'd100, 32'd7, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd14) begin err_cnt++; $display("FAIL pre_reset_q: got %h want %h", r, 32'd14); end
    // start a division and reset it at cycle 10
    @(negedge clk);
    a = 32'd200; b = 32'd3; is_q = 1'b1; req = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (ready !== 1'b0) begin err_cnt++; $display("FAIL midreset_ready: got %b want 0", ready); end
    vec_cnt++;
    if (result !== 32'd0) begin err_cnt++; $display("FAIL midreset_result: got %h want 0", result); end
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_div(32'd100, 32'd7, 1'b0, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd2) begin err_cnt++; $display("FAIL post_reset_r: got %h want %h", r, 32'd2); end
    vec_cnt++;
    if (l !== LAT_NORM) begin err_cnt++; $display("FAIL post_reset_lat: got %0d want %0d", l, LAT_NORM); end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    int          l;
    do_div(32'd100, 32'd7, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd14) begin err_cnt++; $display("FAIL basic_q: got %h want %h", r, 32'd14); end
    vec_cnt++;
    if (l !== LAT_NORM) begin err_cnt++; $display("FAIL basic_q_lat: got %0d want %0d", l, LAT_NORM); end
    do_div(32'd100, 32'd7, 1'b0, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd2) begin err_cnt++; $display("FAIL basic_r: got %h want %h", r, 32'd2); end
    vec_cnt++;
    if (l !== LAT_NORM) begin err_cnt++; $display("FAIL basic_r_lat: got %0d want %0d", l, LAT_NORM); end
  endtask

  task automatic test_large();
    logic [31:0] r;
    int          l;
    do_div(32'hFFFF_FFFF, 32'h0001_0000, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'h0000_FFFF) begin err_cnt++; $display("FAIL large_q: got %h want %h", r, 32'h0000_FFFF); end
    // do_div returns in the cycle after DONE: the pulse must be over
    vec_cnt++;
    if (ready !== 1'b0) begin err_cnt++; $display("FAIL large_pulse: ready=%b one cycle after DONE, want 0", ready); end
    do_div(32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'h0000_FFFF) begin err_cnt++; $display("FAIL large_r: got %h want %h", r, 32'h0000_FFFF); end
    vec_cnt++;
    if (result !== 32'h0000_FFFF) begin err_cnt++; $display("FAIL large_hold: got %h want %h", result, 32'h0000_FFFF); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int          l;
    do_div(32'h1234_5678, 32'd0, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dz_q: got %h want %h", r, 32'hFFFF_FFFF); end
    vec_cnt++;
    if (l !== LAT_FAST) begin err_cnt++; $display("FAIL dz_q_lat: got %0d want %0d", l, LAT_FAST); end
    do_div(32'h1234_5678, 32'd0, 1'b0, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'h1234_5678) begin err_cnt++; $display("FAIL dz_r: got %h want %h", r, 32'h1234_5678); end
    vec_cnt++;
    if (l !== LAT_FAST) begin err_cnt++; $display("FAIL dz_r_lat: got %0d want %0d", l, LAT_FAST); end
  endtask

  task automatic test_small_and_one();
    logic [31:0] r;
    int          l;
    do_div(32'd5, 32'd9, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd0) begin err_cnt++; $display("FAIL altb_q: got %h want 0", r); end
    vec_cnt++;
    if (l !== LAT_FAST) begin err_cnt++; $display("FAIL altb_lat: got %0d want %0d", l, LAT_FAST); end
    do_div(32'd5, 32'd9, 1'b0, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd5) begin err_cnt++; $display("FAIL altb_r: got %h want %h", r, 32'd5); end
    do_div(32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL b1_q: got %h want %h", r, 32'hDEAD_BEEF); end
    vec_cnt++;
    if (l !== LAT_FAST) begin err_cnt++; $display("FAIL b1_lat: got %0d want %0d", l, LAT_FAST); end
    do_div(32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd0) begin err_cnt++; $display("FAIL b1_r: got %h want 0", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int          l;
    int          gap;
    do_div(32'd40, 32'd6, 1'b1, 1'b1, r, l);
    vec_cnt++;
    if (r !== 32'd6) begin err_cnt++; $display("FAIL b2b_first: got %h want %h", r, 32'd6); end
    // still in DONE with req high: present the next operands
    a = 32'd81; b = 32'd9;
    @(posedge clk); #1;
    vec_cnt++;
    if (ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle_gap: ready=%b want 0", ready); end
    gap = -1;
    for (int c = 2; c <= 100; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin gap = c; break; end
    end
    r = result;
    req = 1'b0;
    $display("b2b second: result=%h ready-to-ready=%0d", r, gap);
    vec_cnt++;
    if (r !== 32'd9) begin err_cnt++; $display("FAIL b2b_second: got %h want %h", r, 32'd9); end
    vec_cnt++;
    if (gap !== 34) begin err_cnt++; $display("FAIL b2b_spacing: got %0d want 34", gap); end
    @(posedge clk); #1;
    // abort at BUSY cycle 5
    @(negedge clk);
    a = 32'd1000; b = 32'd3; is_q = 1'b1; req = 1'b1;
    repeat (5) @(posedge clk);
    #1 req = 1'b0;
    gap = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) gap++;
    end
    $display("abort: pulses=%0d result=%h", gap, result);
    vec_cnt++;
    if (gap !== 0) begin err_cnt++; $display("FAIL abort_pulse: got %0d pulses want 0", gap); end
    vec_cnt++;
    if (result !== 32'd9) begin err_cnt++; $display("FAIL abort_hold: got %h want %h", result, 32'd9); end
    do_div(32'd50, 32'd5, 1'b1, 1'b0, r, l);
    vec_cnt++;
    if (r !== 32'd10) begin err_cnt++; $display("FAIL post_abort_q: got %h want %h", r, 32'd10); end
    vec_cnt++;
    if (l !== LAT_NORM) begin err_cnt++; $display("FAIL post_abort_lat: got %0d want %0d", l, LAT_NORM); end
  endtask

  task automatic test_random();
    logic [31:0] av, bv, r, exp_v;
    logic        qv;
    int          l, exp_l;
    for (int i = 0; i < 300; i++) begin
      av = $urandom;
      case (i % 4)
        0:       bv = $urandom;
        1:       bv = $urandom >> $urandom_range(0, 31);
        2:       bv = 32'($urandom_range(0, 15));
        default: bv = 32'($urandom_range(0, 65535));
      endcase
      if (i % 7 == 0) av = av >> $urandom_range(0, 31);
      qv = 1'($urandom_range(0, 1));
      if (bv == 32'd0) exp_v = qv ? 32'hFFFF_FFFF : av;
      else             exp_v = qv ? (av / bv) : (av % bv);
`ifdef DIV_ITER_FAST_EN
      exp_l = (bv == 32'd0 || av < bv || bv == 32'd1) ? 1 : LAT_NORM;
`else
      exp_l = LAT_NORM;
`endif
      do_div(av, bv, qv, 1'b0, r, l);
      vec_cnt++;
      if (r !== exp_v) begin err_cnt++; $display("FAIL rand_result[%0d]: got %h want %h", i, r, exp_v); end
      vec_cnt++;
      if (l !== exp_l) begin err_cnt++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, l, exp_l); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_large();
    test_div_zero();
    test_small_and_one();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
